// File: rtl/sdram_pin_decoder.sv
// Pin-level SDRAM command decoder: tracks bank rows, mode and bursts, and emits
// one single-beat access per cycle plus the CAS-latency-delayed read return.
module sdram_pin_decoder #(
  parameter int unsigned ROW_W = 13,
  parameter int unsigned COL_W = 9,
  parameter int unsigned BA_W  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             ras_n,
  input  logic             cas_n,
  input  logic             we_n,
  input  logic [BA_W-1:0]  ba,
  input  logic [ROW_W-1:0] a,
  input  logic [1:0]       dqm,
  input  logic [15:0]      dq_in,
  output logic [15:0]      dq_out,
  output logic             dq_oe,
  output logic             cmd_valid,
  output logic             cmd_wen,
  output logic [1:0]       cmd_dqm_n,
  output logic [31:0]      cmd_addr,
  output logic [15:0]      cmd_wdata,
  input  logic [15:0]      cmd_rdata,
  output logic             err
);

  localparam int unsigned NB = 1 << BA_W;

  logic [NB-1:0]    open_q, open_d;
  logic [ROW_W-1:0] row_q [NB];
  logic [ROW_W-1:0] row_d [NB];
  logic [1:0]       bl_q, bl_d;
  logic             cl3_q, cl3_d;
  logic             err_q, err_d;

  logic             bst_act_q, bst_act_d;
  logic [BA_W-1:0]  bst_ba_q, bst_ba_d;
  logic [ROW_W-1:0] bst_row_q, bst_row_d;
  logic [COL_W-1:0] bst_col_q, bst_col_d;
  logic [2:0]       bst_cnt_q, bst_cnt_d;
  logic             bst_wen_q, bst_wen_d;

  logic             p0_v_q, p0_v_d, p0_oe_q, p0_oe_d, p0_cl3_q, p0_cl3_d;
  logic             p1_v_q, p1_v_d, p1_oe_q, p1_oe_d;
  logic [15:0]      p1_data_q, p1_data_d;
  logic             dq_oe_q, dq_oe_d;
  logic [15:0]      dq_out_q, dq_out_d;

  logic [2:0]       code;
  logic             is_act, is_rd, is_wr, is_pre, is_lmr;
  logic             new_bst, bad_acc, bst_kill, cont;
  logic [2:0]       bl_mask, col_lo;
  logic             beat_v, beat_wen;
  logic [BA_W-1:0]  beat_ba;
  logic [ROW_W-1:0] beat_row;
  logic [COL_W-1:0] beat_col;

  // Command decode; deselect reads as NOP
  always_comb begin
    code   = cs_n ? 3'b111 : {ras_n, cas_n, we_n};
    is_act = (code == 3'b011);
    is_rd  = (code == 3'b101);
    is_wr  = (code == 3'b100);
    is_pre = (code == 3'b010);
    is_lmr = (code == 3'b000);
  end

  // Beat selection: a fresh READ/WRITE wins over the running burst
  always_comb begin
    bl_mask  = 3'((4'd1 << bl_q) - 4'd1);
    new_bst  = (is_rd || is_wr) && open_q[ba];
    bad_acc  = (is_rd || is_wr) && !open_q[ba];
    bst_kill = bst_act_q && ((is_pre && (a[10] || ba == bst_ba_q)) || is_lmr);
    cont     = bst_act_q && !bst_kill && !new_bst;
    col_lo   = 3'(bst_col_q[2:0] + bst_cnt_q);
    beat_v   = 1'b0;
    beat_wen = 1'b0;
    beat_ba  = '0;
    beat_row = '0;
    beat_col = '0;
    if (new_bst) begin
      beat_v   = 1'b1;
      beat_wen = is_wr;
      beat_ba  = ba;
      beat_row = row_q[ba];
      beat_col = a[COL_W-1:0];
    end else if (cont) begin
      beat_v   = 1'b1;
      beat_wen = bst_wen_q;
      beat_ba  = bst_ba_q;
      beat_row = bst_row_q;
      beat_col = {bst_col_q[COL_W-1:3], (bst_col_q[2:0] & ~bl_mask) | (col_lo & bl_mask)};
    end
  end

  always_comb begin
    cmd_valid = beat_v && !reset;
    cmd_wen   = cmd_valid && beat_wen;
    cmd_addr  = cmd_valid ? 32'({beat_ba, beat_row, beat_col, 1'b0}) : '0;
    cmd_wdata = cmd_wen ? dq_in : '0;
    cmd_dqm_n = cmd_wen ? dqm : 2'b00;
    dq_oe     = dq_oe_q && !is_wr && !reset;
    dq_out    = dq_out_q;
    err       = err_q;
  end

  // Next state for banks, mode, burst and read-return pipeline
  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    bl_d      = bl_q;
    cl3_d     = cl3_q;
    err_d     = err_q | bad_acc | (is_act && open_q[ba]);
    bst_act_d = 1'b0;
    bst_ba_d  = bst_ba_q;
    bst_row_d = bst_row_q;
    bst_col_d = bst_col_q;
    bst_cnt_d = bst_cnt_q;
    bst_wen_d = bst_wen_q;

    if (is_act) begin
      open_d[ba] = 1'b1;
      row_d[ba]  = a;
    end
    if (is_pre) begin
      if (a[10]) open_d = '0;
      else       open_d[ba] = 1'b0;
    end
    if (is_lmr) begin
      bl_d  = a[2] ? 2'd0 : a[1:0];
      cl3_d = (a[6:4] == 3'd3);
    end

    if (new_bst) begin
      bst_act_d = (bl_q != 2'd0);
      bst_ba_d  = ba;
      bst_row_d = row_q[ba];
      bst_col_d = a[COL_W-1:0];
      bst_cnt_d = 3'd1;
      bst_wen_d = is_wr;
    end else if (cont) begin
      bst_act_d = (bst_cnt_q != bl_mask);
      bst_cnt_d = 3'(bst_cnt_q + 3'd1);
    end

    // A WRITE drops every read beat issued before it
    p0_v_d    = beat_v && !beat_wen;
    p0_oe_d   = (dqm != 2'b11);
    p0_cl3_d  = cl3_q;
    p1_v_d    = p0_v_q && p0_cl3_q && !is_wr;
    p1_oe_d   = p0_oe_q;
    p1_data_d = cmd_rdata;
    dq_oe_d   = 1'b0;
    dq_out_d  = dq_out_q;
    if (!is_wr) begin
      if (p0_v_q && !p0_cl3_q) begin
        dq_oe_d  = p0_oe_q;
        dq_out_d = cmd_rdata;
      end else if (p1_v_q) begin
        dq_oe_d  = p1_oe_q;
        dq_out_d = p1_data_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      open_q    <= '0;
      for (int unsigned i = 0; i < NB; i++) row_q[i] <= '0;
      bl_q      <= 2'd0;
      cl3_q     <= 1'b0;
      err_q     <= 1'b0;
      bst_act_q <= 1'b0;
      bst_ba_q  <= '0;
      bst_row_q <= '0;
      bst_col_q <= '0;
      bst_cnt_q <= '0;
      bst_wen_q <= 1'b0;
      p0_v_q    <= 1'b0;
      p0_oe_q   <= 1'b0;
      p0_cl3_q  <= 1'b0;
      p1_v_q    <= 1'b0;
      p1_oe_q   <= 1'b0;
      p1_data_q <= '0;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
    end else begin
      open_q    <= open_d;
      row_q     <= row_d;
      bl_q      <= bl_d;
      cl3_q     <= cl3_d;
      err_q     <= err_d;
      bst_act_q <= bst_act_d;
      bst_ba_q  <= bst_ba_d;
      bst_row_q <= bst_row_d;
      bst_col_q <= bst_col_d;
      bst_cnt_q <= bst_cnt_d;
      bst_wen_q <= bst_wen_d;
      p0_v_q    <= p0_v_d;
      p0_oe_q   <= p0_oe_d;
      p0_cl3_q  <= p0_cl3_d;
      p1_v_q    <= p1_v_d;
      p1_oe_q   <= p1_oe_d;
      p1_data_q <= p1_data_d;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_sdram_pin_decoder.sv
// Bench for sdram_pin_decoder: directed scenarios then random pin traffic,
// every cycle checked against a queue/schedule-based model of the device.
module tb_sdram_pin_decoder;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_LMR = 4'b0000, C_DES = 4'b1000;

  logic        clock = 1'b0;
  logic        reset, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm, cmd_dqm_n;
  logic [12:0] a;
  logic [15:0] dq_in, dq_out, cmd_wdata, cmd_rdata;
  logic        dq_oe, cmd_valid, cmd_wen, err;
  logic [31:0] cmd_addr;

  sdram_pin_decoder dut (
    .clock(clock), .reset(reset), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .a(a), .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .cmd_valid(cmd_valid), .cmd_wen(cmd_wen),
    .cmd_dqm_n(cmd_dqm_n), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          bank;
    logic [31:0] addr;
    bit          wen;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  bit          m_open [4];
  logic [12:0] m_row [4];
  int          m_bl = 1;
  int          m_cl = 2;
  bit          m_err = 1'b0;
  beat_t       q [$];
  logic [15:0] exp_dq_at [int];
  bit          prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [15:0] rhash(input logic [31:0] ad);
    return 16'((ad >> 1) * 32'd40503 + 32'h1234);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
    end
    m_bl = 1; m_cl = 2; m_err = 1'b0;
    q.delete();
    exp_dq_at.delete();
    prev_rd = 1'b0;
  endtask

  // One clock cycle: drive pins, check outputs mid-cycle, advance the model
  task automatic cyc(input bit rst, input logic [3:0] c, input int b,
                     input logic [12:0] aa, input logic [1:0] m, input logic [15:0] d);
    logic [2:0] code;
    beat_t bt;
    bit    ev, new_err;
    int    bl, cc, col;
    reset = rst; {cs_n, ras_n, cas_n, we_n} = c;
    ba = 2'(b); a = aa; dqm = m; dq_in = d;
    cmd_rdata = prev_rd ? rhash(prev_addr) : 16'($urandom);
    @(negedge clock);
    if (rst) begin
      chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("reset_dq_oe", 32'(dq_oe), 32'd0);
      model_reset();
    end else begin
      code = c[3] ? 3'b111 : c[2:0];
      new_err = 1'b0;
      ev = 1'b0;
      if (code == 3'b101 || code == 3'b100) begin
        if (m_open[b]) begin
          q.delete();
          bl = m_bl;
          cc = int'(aa[8:0]);
          for (int k = 0; k < bl; k++) begin
            col = (cc & ~(bl - 1)) | ((cc + k) & (bl - 1));
            q.push_back('{b, {7'd0, 2'(b), m_row[b], 9'(col), 1'b0}, code == 3'b100});
          end
        end else new_err = 1'b1;
      end
      if (code == 3'b010 && q.size() > 0 && (aa[10] || q[0].bank == b)) q.delete();
      if (code == 3'b000) q.delete();
      if (code == 3'b100)
        for (int k = 0; k < 4; k++) exp_dq_at.delete(cyc_n + k);
      if (q.size() > 0) begin
        bt = q.pop_front();
        ev = 1'b1;
      end
      chk("cmd_valid", 32'(cmd_valid), 32'(ev));
      prev_rd = 1'b0;
      if (ev) begin
        chk("cmd_wen", 32'(cmd_wen), 32'(bt.wen));
        chk("cmd_addr", cmd_addr, bt.addr);
        if (bt.wen) begin
          chk("cmd_wdata", 32'(cmd_wdata), 32'(d));
          chk("cmd_dqm_n", 32'(cmd_dqm_n), 32'(m));
        end else begin
          chk("rd_dqm_n", 32'(cmd_dqm_n), 32'd0);
          prev_rd = 1'b1;
          prev_addr = bt.addr;
          if (m != 2'b11) exp_dq_at[cyc_n + m_cl] = rhash(bt.addr);
        end
      end
      chk("dq_oe", 32'(dq_oe), 32'(exp_dq_at.exists(cyc_n)));
      if (exp_dq_at.exists(cyc_n)) begin
        chk("dq_out", 32'(dq_out), 32'(exp_dq_at[cyc_n]));
        exp_dq_at.delete(cyc_n);
      end
      chk("err", 32'(err), 32'(m_err));
      if (code == 3'b011) begin
        if (m_open[b]) new_err = 1'b1;
        m_open[b] = 1'b1;
        m_row[b] = aa;
      end
      if (code == 3'b010) begin
        if (aa[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        else m_open[b] = 1'b0;
      end
      if (code == 3'b000) begin
        m_bl = (aa[2:0] < 3'd4) ? (1 << aa[1:0]) : 1;
        m_cl = (aa[6:4] == 3'd3) ? 3 : 2;
      end
      m_err = m_err | new_err;
    end
    cyc_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) cyc(1'b0, C_NOP, 0, 13'd0, m, 16'($urandom));
  endtask

  initial begin
    logic [3:0]  c;
    logic [12:0] aa;
    logic [1:0]  m;
    int          r;
    bit          rst;
    model_reset();
    @(posedge clock); #1;
    cyc(1'b1, C_NOP, 0, 13'd0, 2'b00, 16'd0);
    cyc(1'b1, C_NOP, 0, 13'd0, 2'b00, 16'd0);
    idle(1, 2'b00);

    // Single write after ACTIVE
    cyc(1'b0, C_ACT, 1, 13'h0123, 2'b00, 16'd0);
    cyc(1'b0, C_WR, 1, 13'h0010, 2'b00, 16'hBEEF);
    idle(2, 2'b00);

    // BL=4 CL=3 read with wrap inside the aligned block
    cyc(1'b0, C_LMR, 0, 13'h0032, 2'b00, 16'd0);
    cyc(1'b0, C_ACT, 0, 13'h0005, 2'b00, 16'd0);
    cyc(1'b0, C_RD, 0, 13'h0006, 2'b00, 16'd0);
    idle(8, 2'b00);

    // BL=1 CL=2 read fully masked
    cyc(1'b0, C_LMR, 0, 13'h0000, 2'b00, 16'd0);
    cyc(1'b0, C_RD, 0, 13'h0003, 2'b11, 16'd0);
    idle(4, 2'b00);

    // BL=8 write burst interrupted at beat 3
    cyc(1'b0, C_LMR, 0, 13'h0003, 2'b00, 16'd0);
    cyc(1'b0, C_WR, 0, 13'h0020, 2'b01, 16'h1111);
    idle(2, 2'b01);
    cyc(1'b0, C_WR, 0, 13'h004B, 2'b01, 16'h2222);
    idle(9, 2'b01);

    // Closed-bank accesses and all-bank precharge
    cyc(1'b0, C_RD, 2, 13'h0000, 2'b00, 16'd0);
    idle(2, 2'b00);
    cyc(1'b0, C_PRE, 0, 13'h0400, 2'b00, 16'd0);
    cyc(1'b0, C_RD, 0, 13'h0001, 2'b00, 16'd0);
    idle(2, 2'b00);

    // Reset mid-burst, then READ with no open bank
    cyc(1'b1, C_NOP, 0, 13'd0, 2'b00, 16'd0);
    cyc(1'b0, C_LMR, 0, 13'h0002, 2'b00, 16'd0);
    cyc(1'b0, C_ACT, 1, 13'h0077, 2'b00, 16'd0);
    cyc(1'b0, C_RD, 1, 13'h0008, 2'b00, 16'd0);
    idle(1, 2'b00);
    cyc(1'b1, C_NOP, 0, 13'd0, 2'b00, 16'd0);
    idle(1, 2'b00);
    cyc(1'b0, C_RD, 1, 13'h0008, 2'b00, 16'd0);
    idle(2, 2'b00);
    cyc(1'b1, C_NOP, 0, 13'd0, 2'b00, 16'd0);

    // Random pin traffic
    for (int i = 0; i < 4000; i++) begin
      r   = int'($urandom_range(0, 99));
      aa  = 13'($urandom);
      m   = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if      (r < 20) c = C_ACT;
      else if (r < 40) c = C_RD;
      else if (r < 55) c = C_WR;
      else if (r < 75) c = C_NOP;
      else if (r < 83) begin c = C_PRE; aa[10] = ($urandom_range(0, 3) == 0); end
      else if (r < 88) c = C_LMR;
      else if (r < 92) c = C_REF;
      else             c = C_DES;
      cyc(rst, c, int'($urandom_range(0, 3)), aa, m, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
